// File: rtl/itable_xpt_sequencer.sv
// Opcode capture (ITABLE) and execution-step counter (XPT) feeding the instruction decoder.
// Every output, including the complements, comes straight from a flop.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_FETCH | waiting for an M1 opcode; CM1 high, decoder disabled
//   ST_EXEC  | opcode latched; XPT steps, decoder enabled
module itable_xpt_sequencer #(
    parameter int unsigned XPT_MAX      = 15,
    parameter logic [7:0]  CLEAR_OPCODE = 8'h00
) (
    input  logic       CLK,
    input  logic       notRESET,
    input  logic [7:0] DataIn,
    input  logic       OpcodeValid,
    input  logic       Step,
    input  logic       notWAIT,
    input  logic       P2_Set_CM1,
    input  logic       P2_Reset_ITABLE,
    input  logic       PR_Reset_XPT,
    output logic [7:0] ITABLE,
    output logic [7:0] notITABLE,
    output logic [3:0] XPT,
    output logic [3:0] notXPT,
    output logic       enable,
    output logic       CM1,
    output logic       XPT_Saturated
);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } state_t;

    localparam logic [3:0] XPT_TOP = 4'(XPT_MAX);

    state_t     state_q, state_d;
    logic [7:0] itable_q, itable_d;
    logic [7:0] nitable_q, nitable_d;
    logic [3:0] xpt_q, xpt_d;
    logic [3:0] nxpt_q, nxpt_d;
    logic       enable_q, enable_d;
    logic       cm1_q, cm1_d;
    logic       sat_q, sat_d;

    always_ff @(posedge CLK) begin
        if (!notRESET) begin
            state_q   <= ST_FETCH;
            itable_q  <= CLEAR_OPCODE;
            nitable_q <= ~CLEAR_OPCODE;
            xpt_q     <= 4'h0;
            nxpt_q    <= 4'hF;
            enable_q  <= 1'b0;
            cm1_q     <= 1'b1;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            itable_q  <= itable_d;
            nitable_q <= nitable_d;
            xpt_q     <= xpt_d;
            nxpt_q    <= nxpt_d;
            enable_q  <= enable_d;
            cm1_q     <= cm1_d;
            sat_q     <= sat_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        itable_d = itable_q;
        xpt_d    = xpt_q;
        sat_d    = sat_q;

        if (notWAIT) begin
            case (state_q)
                ST_FETCH: begin
                    if (OpcodeValid) begin
                        itable_d = DataIn;
                        xpt_d    = 4'h0;
                        sat_d    = 1'b0;
                        state_d  = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (P2_Set_CM1) begin
                        state_d = ST_FETCH;
                        xpt_d   = 4'h0;
                    end else if (PR_Reset_XPT) begin
                        xpt_d = 4'h0;
                    end else if (Step) begin
                        // Saturate rather than wrap; the flag records the lost step.
                        if (xpt_q < XPT_TOP) xpt_d = xpt_q + 4'h1;
                        else                 sat_d = 1'b1;
                    end
                    if (P2_Reset_ITABLE) itable_d = CLEAR_OPCODE;
                end
                default: state_d = ST_FETCH;
            endcase
        end

        nitable_d = ~itable_d;
        nxpt_d    = ~xpt_d;
        enable_d  = (state_d == ST_EXEC);
        cm1_d     = (state_d == ST_FETCH);
    end

    assign ITABLE        = itable_q;
    assign notITABLE     = nitable_q;
    assign XPT           = xpt_q;
    assign notXPT        = nxpt_q;
    assign enable        = enable_q;
    assign CM1           = cm1_q;
    assign XPT_Saturated = sat_q;

endmodule

// File: tb/tb_itable_xpt_sequencer.sv
// Bench for itable_xpt_sequencer: a vector table plus hand sequences for saturation and mid-op reset.
module tb_itable_xpt_sequencer;

    logic       CLK = 1'b0;
    logic       notRESET, OpcodeValid, Step, notWAIT;
    logic       P2_Set_CM1, P2_Reset_ITABLE, PR_Reset_XPT;
    logic [7:0] DataIn;
    logic [7:0] ITABLE, notITABLE;
    logic [3:0] XPT, notXPT;
    logic       enable, CM1, XPT_Saturated;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    itable_xpt_sequencer #(.XPT_MAX(15), .CLEAR_OPCODE(8'h00)) dut (
        .CLK(CLK), .notRESET(notRESET), .DataIn(DataIn), .OpcodeValid(OpcodeValid),
        .Step(Step), .notWAIT(notWAIT), .P2_Set_CM1(P2_Set_CM1),
        .P2_Reset_ITABLE(P2_Reset_ITABLE), .PR_Reset_XPT(PR_Reset_XPT),
        .ITABLE(ITABLE), .notITABLE(notITABLE), .XPT(XPT), .notXPT(notXPT),
        .enable(enable), .CM1(CM1), .XPT_Saturated(XPT_Saturated)
    );

    typedef struct packed {
        logic       rst_n;
        logic       ov;
        logic       step;
        logic       nwait;
        logic       setcm1;
        logic       rstit;
        logic       rstxpt;
        logic [7:0] din;
        logic [7:0] e_it;
        logic [3:0] e_xpt;
        logic       e_en;
        logic       e_cm1;
        logic       e_sat;
    } vec_t;

    vec_t exp_q[$];
    vec_t vecs[18];

    function automatic vec_t mk(input logic rst_n, input logic ov, input logic step,
                                input logic nwait, input logic setcm1, input logic rstit,
                                input logic rstxpt, input logic [7:0] din,
                                input logic [7:0] e_it, input logic [3:0] e_xpt,
                                input logic e_en, input logic e_cm1, input logic e_sat);
        vec_t v;
        v.rst_n = rst_n; v.ov = ov; v.step = step; v.nwait = nwait;
        v.setcm1 = setcm1; v.rstit = rstit; v.rstxpt = rstxpt; v.din = din;
        v.e_it = e_it; v.e_xpt = e_xpt; v.e_en = e_en; v.e_cm1 = e_cm1; v.e_sat = e_sat;
        return v;
    endfunction

    task automatic chk(input string tag, input string fld, input logic [7:0] act,
                       input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s: got %h required %h", tag, fld, act, req);
        end
    endtask

    task automatic drive(input vec_t v, input string tag);
        vec_t e;
        notRESET        = v.rst_n;
        OpcodeValid     = v.ov;
        Step            = v.step;
        notWAIT         = v.nwait;
        P2_Set_CM1      = v.setcm1;
        P2_Reset_ITABLE = v.rstit;
        PR_Reset_XPT    = v.rstxpt;
        DataIn          = v.din;
        exp_q.push_back(v);
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        chk(tag, "ITABLE",    ITABLE,           e.e_it);
        chk(tag, "notITABLE", notITABLE,        ~e.e_it);
        chk(tag, "XPT",       {4'h0, XPT},      {4'h0, e.e_xpt});
        chk(tag, "notXPT",    {4'h0, notXPT},   {4'h0, ~e.e_xpt});
        chk(tag, "enable",    {7'h0, enable},   {7'h0, e.e_en});
        chk(tag, "CM1",       {7'h0, CM1},      {7'h0, e.e_cm1});
        chk(tag, "sat",       {7'h0, XPT_Saturated}, {7'h0, e.e_sat});
    endtask

    initial begin
        //                rst ov st nw cm rit rx  din     it     xpt  en cm1 sat
        vecs[0]  = mk(0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 4'h0, 0, 1, 0);
        vecs[1]  = mk(0, 1, 1, 1, 0, 0, 0, 8'h44, 8'h00, 4'h0, 0, 1, 0);
        vecs[2]  = mk(1, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 4'h0, 0, 1, 0);
        vecs[3]  = mk(1, 1, 0, 1, 0, 0, 0, 8'h31, 8'h31, 4'h0, 1, 0, 0);
        vecs[4]  = mk(1, 0, 1, 1, 0, 0, 0, 8'h00, 8'h31, 4'h1, 1, 0, 0);
        vecs[5]  = mk(1, 0, 1, 1, 0, 0, 0, 8'h00, 8'h31, 4'h2, 1, 0, 0);
        vecs[6]  = mk(1, 0, 1, 1, 0, 0, 0, 8'h00, 8'h31, 4'h3, 1, 0, 0);
        vecs[7]  = mk(1, 1, 1, 1, 1, 1, 0, 8'h3A, 8'h00, 4'h0, 0, 1, 0);
        vecs[8]  = mk(1, 1, 0, 1, 0, 0, 0, 8'h55, 8'h55, 4'h0, 1, 0, 0);
        vecs[9]  = mk(1, 0, 1, 1, 0, 0, 0, 8'h00, 8'h55, 4'h1, 1, 0, 0);
        vecs[10] = mk(1, 0, 1, 1, 0, 0, 0, 8'h00, 8'h55, 4'h2, 1, 0, 0);
        vecs[11] = mk(1, 0, 1, 1, 0, 0, 1, 8'h00, 8'h55, 4'h0, 1, 0, 0);
        vecs[12] = mk(1, 0, 1, 1, 0, 0, 0, 8'h00, 8'h55, 4'h1, 1, 0, 0);
        vecs[13] = mk(1, 0, 1, 0, 1, 1, 1, 8'h00, 8'h55, 4'h1, 1, 0, 0);
        vecs[14] = mk(1, 1, 1, 1, 0, 0, 0, 8'h99, 8'h55, 4'h2, 1, 0, 0);
        vecs[15] = mk(1, 0, 0, 1, 1, 0, 0, 8'h00, 8'h55, 4'h0, 0, 1, 0);
        vecs[16] = mk(1, 0, 1, 1, 1, 1, 1, 8'h00, 8'h55, 4'h0, 0, 1, 0);
        vecs[17] = mk(1, 1, 0, 0, 0, 0, 0, 8'h77, 8'h55, 4'h0, 0, 1, 0);

        for (int i = 0; i < 18; i++) drive(vecs[i], $sformatf("vec%0d", i));

        // Saturation: 17 steps after a fetch; the 16th finds XPT at the top.
        drive(mk(1, 1, 0, 1, 0, 0, 0, 8'hC3, 8'hC3, 4'h0, 1, 0, 0), "sat_fetch");
        for (int i = 1; i <= 17; i++) begin
            logic [3:0] ex;
            ex = (i > 15) ? 4'hF : 4'(i);
            drive(mk(1, 0, 1, 1, 0, 0, 0, 8'h00, 8'hC3, ex, 1, 0, (i >= 16) ? 1'b1 : 1'b0),
                  $sformatf("sat_step%0d", i));
        end
        drive(mk(1, 0, 0, 1, 1, 0, 0, 8'h00, 8'hC3, 4'h0, 0, 1, 1), "sat_end");
        drive(mk(1, 1, 0, 1, 0, 0, 0, 8'h12, 8'h12, 4'h0, 1, 0, 0), "sat_clear");
        drive(mk(1, 0, 0, 1, 1, 0, 0, 8'h00, 8'h12, 4'h0, 0, 1, 0), "sat_ret");

        // Reset in the middle of an instruction, overriding stall and step.
        drive(mk(1, 1, 0, 1, 0, 0, 0, 8'h01, 8'h01, 4'h0, 1, 0, 0), "mid_fetch");
        for (int i = 1; i <= 5; i++)
            drive(mk(1, 0, 1, 1, 0, 0, 0, 8'h00, 8'h01, 4'(i), 1, 0, 0),
                  $sformatf("mid_step%0d", i));
        drive(mk(0, 1, 1, 0, 0, 0, 0, 8'hEE, 8'h00, 4'h0, 0, 1, 0), "mid_reset");
        drive(mk(1, 0, 1, 1, 0, 0, 0, 8'h00, 8'h00, 4'h0, 0, 1, 0), "post_reset");

        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard: %0d entries left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/itable_xpt_sequencer.md
Name: itable_xpt_sequencer

Overview:
- Upstream stage of the instruction decoder tree.
- Captures the fetched opcode byte into the ITABLE register and runs the XPT execution-step counter.
- Drives both registers, their exact complements, and the decoder enable.
- Closes the loop with the decoder: consumes its end-of-instruction and step-reset strobes (P2_Set_CM1, P2_Reset_ITABLE, PR_Reset_XPT) to return to opcode fetch.

Parameters:
- XPT_MAX, 15: highest XPT value. XPT saturates here and must be ≤ 15.
- CLEAR_OPCODE, 8'h00: value ITABLE takes at reset and on P2_Reset_ITABLE.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- notRESET  input  1  reset; synchronous, active-low.
- DataIn  input  8  opcode byte from the data bus.
- OpcodeValid  input  1  DataIn holds a valid opcode this cycle (M1 read strobe).
- Step  input  1  advance XPT by one (machine-cycle boundary).
- notWAIT  input  1  low = stall; holds all state.
- P2_Set_CM1  input  1  decoder: instruction complete, return to fetch.
- P2_Reset_ITABLE  input  1  decoder: clear ITABLE.
- PR_Reset_XPT  input  1  decoder: clear XPT.
- ITABLE  output  8  latched opcode.
- notITABLE  output  8  bitwise complement of ITABLE.
- XPT  output  4  execution step.
- notXPT  output  4  bitwise complement of XPT.
- enable  output  1  decoder enable; high only in EXEC.
- CM1  output  1  high in FETCH (opcode fetch cycle pending).
- XPT_Saturated  output  1  sticky: a Step arrived while XPT == XPT_MAX.

Behaviour:
- All outputs are registered. Each complement output is a separate register updated on the same edge, so ITABLE ^ notITABLE == 8'hFF and XPT ^ notXPT == 4'hF in every cycle, including the reset cycle.
- Reset (notRESET low at an edge) wins over every other input and works the same mid-instruction:
  - state = FETCH
  - ITABLE = CLEAR_OPCODE, notITABLE = ~CLEAR_OPCODE
  - XPT = 0, notXPT = 4'hF
  - enable = 0, CM1 = 1, XPT_Saturated = 0
- Stall: notWAIT low with notRESET high → every register holds, regardless of all other inputs.
- States: FETCH, EXEC (1-bit encoding).
- FETCH:
  - OpcodeValid = 1 → ITABLE = DataIn, XPT = 0, XPT_Saturated = 0, next state EXEC.
  - One cycle of latency: ITABLE, enable = 1 and CM1 = 0 all appear together on the following cycle.
  - Step, PR_Reset_XPT, P2_Set_CM1 and P2_Reset_ITABLE are ignored in FETCH.
- EXEC:
  - OpcodeValid is ignored.
  - Priority per cycle: P2_Set_CM1 > PR_Reset_XPT > Step.
  - P2_Set_CM1 → next state FETCH, enable = 0, CM1 = 1, XPT = 0.
  - PR_Reset_XPT (without P2_Set_CM1) → XPT = 0 and the same-cycle Step is dropped.
  - Step alone with XPT < XPT_MAX → XPT = XPT + 1.
  - Step alone with XPT == XPT_MAX → XPT holds and XPT_Saturated = 1.
  - P2_Reset_ITABLE → ITABLE = CLEAR_OPCODE. This is independent of the priority chain and may coincide with P2_Set_CM1.
  - Without P2_Reset_ITABLE, ITABLE holds its value through the return to FETCH.
- The decoder strobes are combinational functions of ITABLE and XPT. This block registers them on the next edge only; it has no combinational path from input to output.
- XPT width is fixed at 4 bits. No wrap-around is permitted; a wrap to 0 is a failure.

Test Plan:
- Reset and complements: notRESET low for 2 cycles, then high → ITABLE = 00, notITABLE = FF, XPT = 0, notXPT = F, CM1 = 1, enable = 0.
- Fetch and steps: OpcodeValid with DataIn = 8'h31 → next cycle ITABLE = 31, notITABLE = CE, enable = 1, CM1 = 0; 3 Steps → XPT = 3, notXPT = C.
- End of instruction: P2_Set_CM1 + P2_Reset_ITABLE together with Step and OpcodeValid (DataIn = 8'h3A) → next cycle CM1 = 1, enable = 0, XPT = 0, ITABLE = 00; 3A is not captured.
- Step-reset priority: at XPT = 2, PR_Reset_XPT + Step → XPT = 0. Step with notWAIT low → XPT holds. Step with OpcodeValid in EXEC → ITABLE unchanged.
- Saturation: XPT_MAX = 15, 17 Steps after fetch → XPT = F, XPT_Saturated = 1; the next fetch clears the flag.
- Reset mid-operation: in EXEC with XPT = 5 and ITABLE = 8'h01, notRESET low for one edge → full reset values next cycle, even with notWAIT low and Step high.
